// File: rtl/opc_dispatch_if.sv
// Purpose : Bundles the OPC allocation and dispatch signals between the
//           scoreboard/scheduler side and the OPC dispatch controller.
// Signals : alloc_valid/alloc_ready/alloc_opc   - allocation handshake
//           opc_busy/opc_wait_mask/opc_ready    - per-OPC status from the scheduler
//           dispatch_valid/dispatch_opc/dispatch_ready - dispatch handshake
//           dequeue/dequeue_opc                 - dequeue strobe to the scheduler
//           perf_stalls                         - stall cycle counter
// Modports: master = scheduler/scoreboard/execute side, slave = controller.
interface opc_dispatch_if #(
  parameter int NUM_OPCS  = 4,
  parameter int OPC_WIDTH = (NUM_OPCS > 1) ? $clog2(NUM_OPCS) : 1
);
  logic                         alloc_valid;
  logic                         alloc_ready;
  logic [OPC_WIDTH-1:0]         alloc_opc;
  logic [NUM_OPCS-1:0]          opc_busy;
  logic [NUM_OPCS*NUM_OPCS-1:0] opc_wait_mask;
  logic [NUM_OPCS-1:0]          opc_ready;
  logic                         dispatch_valid;
  logic [OPC_WIDTH-1:0]         dispatch_opc;
  logic                         dispatch_ready;
  logic                         dequeue;
  logic [OPC_WIDTH-1:0]         dequeue_opc;
  logic [31:0]                  perf_stalls;

  modport master (
    output alloc_valid, opc_busy, opc_wait_mask, opc_ready, dispatch_ready,
    input  alloc_ready, alloc_opc, dispatch_valid, dispatch_opc,
           dequeue, dequeue_opc, perf_stalls
  );

  modport slave (
    input  alloc_valid, opc_busy, opc_wait_mask, opc_ready, dispatch_ready,
    output alloc_ready, alloc_opc, dispatch_valid, dispatch_opc,
           dequeue, dequeue_opc, perf_stalls
  );
endinterface

// File: rtl/opc_dispatch_ctrl.sv
// Purpose : Operand collector pool controller. Grants the lowest free OPC to
//           each scoreboard enqueue and picks the next filled OPC to dispatch
//           with round-robin fairness, honouring the pairwise wait mask.
// Ports   : clk   - clock
//           reset - synchronous, active-high reset
//           bus   - opc_dispatch_if.slave (allocation, OPC status, dispatch,
//                   dequeue strobe and stall counter)
module opc_dispatch_ctrl #(
  parameter int NUM_OPCS  = 4,
  parameter int OPC_WIDTH = (NUM_OPCS > 1) ? $clog2(NUM_OPCS) : 1
) (
  input  logic           clk,
  input  logic           reset,
  opc_dispatch_if.slave  bus
);

  logic                   r_dispatch_valid;
  logic [OPC_WIDTH-1:0]   r_dispatch_opc;
  logic [OPC_WIDTH-1:0]   r_rr_ptr;
  logic                   r_hold_valid;
  logic [OPC_WIDTH-1:0]   r_hold_opc;
  logic [31:0]            r_perf_stalls;

  logic [NUM_OPCS-1:0]    w_free;
  logic [NUM_OPCS-1:0]    w_elig;
  logic [2*NUM_OPCS-1:0]  w_elig_dbl;
  logic [NUM_OPCS-1:0]    w_elig_rot;
  logic                   w_alloc_ready;
  logic [OPC_WIDTH-1:0]   w_alloc_opc;
  logic                   w_alloc_fire;
  logic [OPC_WIDTH:0]     w_sel_sum;
  logic [OPC_WIDTH-1:0]   w_sel;
  logic [OPC_WIDTH-1:0]   w_rr_next;
  logic                   w_fire;
  logic                   w_load;
  logic                   w_stall;
  logic [NUM_OPCS-1:0]    w_sel_row;

  // Per-OPC free and eligible flags. An OPC granted last cycle is still
  // reported idle by the scheduler, so the hold register masks it out.
  for (genvar gi = 0; gi < NUM_OPCS; gi++) begin : g_opc
    assign w_free[gi] = ~bus.opc_busy[gi] &
                        ~(r_hold_valid && (r_hold_opc == OPC_WIDTH'(gi)));
    assign w_elig[gi] = bus.opc_busy[gi] & bus.opc_ready[gi] &
                        ~|bus.opc_wait_mask[gi*NUM_OPCS +: NUM_OPCS] &
                        ~(r_dispatch_valid && (r_dispatch_opc == OPC_WIDTH'(gi)));
  end

  assign w_alloc_ready = |w_free;
  assign w_alloc_fire  = bus.alloc_valid & w_alloc_ready;

  // Lowest-index free OPC wins the allocation.
  always_comb begin
    w_alloc_opc = '0;
    for (int i = NUM_OPCS - 1; i >= 0; i--) begin
      if (w_free[i]) w_alloc_opc = OPC_WIDTH'(i);
    end
  end

  // Round-robin: rotate elig so bit 0 corresponds to rr_ptr, take the lowest
  // set bit, then map the offset back to an absolute OPC index.
  assign w_elig_dbl = {w_elig, w_elig} >> r_rr_ptr;
  assign w_elig_rot = w_elig_dbl[NUM_OPCS-1:0];

  always_comb begin
    w_sel_sum = {1'b0, r_rr_ptr};
    for (int k = NUM_OPCS - 1; k >= 0; k--) begin
      if (w_elig_rot[k]) w_sel_sum = {1'b0, r_rr_ptr} + (OPC_WIDTH+1)'(k);
    end
    if (w_sel_sum >= (OPC_WIDTH+1)'(NUM_OPCS)) begin
      w_sel_sum = w_sel_sum - (OPC_WIDTH+1)'(NUM_OPCS);
    end
    w_sel = w_sel_sum[OPC_WIDTH-1:0];
  end

  assign w_rr_next = (w_sel == OPC_WIDTH'(NUM_OPCS - 1)) ? '0 : w_sel + 1'b1;
  assign w_fire    = r_dispatch_valid & bus.dispatch_ready;
  assign w_stall   = r_dispatch_valid & ~bus.dispatch_ready;
  assign w_load    = (|w_elig) & (~r_dispatch_valid | bus.dispatch_ready);
  assign w_sel_row = bus.opc_wait_mask[int'(w_sel)*NUM_OPCS +: NUM_OPCS];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dispatch_valid <= 1'b0;
      r_dispatch_opc   <= '0;
      r_rr_ptr         <= '0;
      r_hold_valid     <= 1'b0;
      r_hold_opc       <= '0;
      r_perf_stalls    <= '0;
    end else begin
      r_hold_valid <= w_alloc_fire;
      r_hold_opc   <= w_alloc_opc;
      if (w_load) begin
        r_dispatch_valid <= 1'b1;
        r_dispatch_opc   <= w_sel;
        r_rr_ptr         <= w_rr_next;
      end else if (w_fire) begin
        r_dispatch_valid <= 1'b0;
      end
      if (w_stall && (r_perf_stalls != 32'hFFFF_FFFF)) begin
        r_perf_stalls <= r_perf_stalls + 32'd1;
      end
    end
  end

  assign bus.alloc_ready    = w_alloc_ready;
  assign bus.alloc_opc      = w_alloc_opc;
  assign bus.dispatch_valid = r_dispatch_valid;
  assign bus.dispatch_opc   = r_dispatch_opc;
  assign bus.dequeue        = w_fire;
  assign bus.dequeue_opc    = r_dispatch_opc;
  assign bus.perf_stalls    = r_perf_stalls;

  // Simulation checks on the handshake invariants.
  a_no_busy_alloc: assert property (@(posedge clk)
    (!reset && w_alloc_fire) |-> !bus.opc_busy[w_alloc_opc]);
  a_stall_stable: assert property (@(posedge clk)
    (!reset && w_stall) |=> (r_dispatch_valid && $stable(r_dispatch_opc)));
  a_no_wait_load: assert property (@(posedge clk)
    (!reset && w_load) |-> (w_sel_row == '0));

endmodule

// File: tb/tb_opc_dispatch_ctrl.sv
module tb_opc_dispatch_ctrl;
  localparam int N = 4;
  localparam int W = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  opc_dispatch_if #(.NUM_OPCS(N), .OPC_WIDTH(W)) bus ();
  opc_dispatch_ctrl #(.NUM_OPCS(N), .OPC_WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the controller's architectural state.
  bit          m_dv;
  int          m_dop;
  int          m_rr;
  bit          m_hv;
  int          m_hold;
  logic [31:0] m_stalls;

  // Scheduler / scoreboard environment model.
  logic [N-1:0]   s_busy;
  logic [N-1:0]   s_ready;
  logic [N*N-1:0] s_wait;
  bit             s_pv;
  int             s_popc;
  bit             s_auto_clear;
  bit             s_rand_wait;

  // Per-cycle decisions taken by the model in eval(), applied in adv().
  bit e_rst, e_fire_a, e_deq, e_ld, e_stall;
  int e_aopc, e_sel, e_dqopc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic eval();
    logic [N-1:0] free, elig;
    bit arv;
    bus.opc_busy      = s_busy;
    bus.opc_ready     = s_ready;
    bus.opc_wait_mask = s_wait;
    #1;
    e_rst = reset;
    for (int i = 0; i < N; i++) begin
      free[i] = !s_busy[i] && !(m_hv && m_hold == i);
      elig[i] = s_busy[i] && s_ready[i] && (s_wait[i*N +: N] == '0) && !(m_dv && m_dop == i);
    end
    arv = |free;
    e_aopc = 0;
    for (int i = N - 1; i >= 0; i--) if (free[i]) e_aopc = i;
    e_sel = -1;
    for (int k = 0; k < N; k++) begin
      if (e_sel < 0 && elig[(m_rr + k) % N]) e_sel = (m_rr + k) % N;
    end
    e_deq    = m_dv && bus.dispatch_ready;
    e_dqopc  = m_dop;
    e_ld     = (e_sel >= 0) && (!m_dv || bus.dispatch_ready);
    e_stall  = m_dv && !bus.dispatch_ready;
    e_fire_a = bus.alloc_valid && arv;
    chk("alloc_ready", 32'(bus.alloc_ready), 32'(arv));
    if (arv) chk("alloc_opc", 32'(bus.alloc_opc), 32'(e_aopc));
    chk("dispatch_valid", 32'(bus.dispatch_valid), 32'(m_dv));
    if (m_dv) chk("dispatch_opc", 32'(bus.dispatch_opc), 32'(m_dop));
    chk("dequeue", 32'(bus.dequeue), 32'(e_deq));
    if (e_deq) chk("dequeue_opc", 32'(bus.dequeue_opc), 32'(m_dop));
    chk("perf_stalls", bus.perf_stalls, m_stalls);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    if (e_rst) begin
      m_dv = 0; m_dop = 0; m_rr = 0; m_hv = 0; m_hold = 0; m_stalls = '0;
    end else begin
      if (e_stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      m_hv   = e_fire_a;
      m_hold = e_aopc;
      if (e_ld) begin
        m_dop = e_sel; m_dv = 1; m_rr = (e_sel + 1) % N;
      end else if (e_deq) begin
        m_dv = 0;
      end
    end
    // Scheduler: dequeue clears busy/ready/wait bits at the next edge;
    // an enqueue shows up as busy two edges after the grant.
    if (e_deq && s_auto_clear) begin
      s_busy[e_dqopc]  = 1'b0;
      s_ready[e_dqopc] = 1'b0;
      for (int j = 0; j < N; j++) begin
        s_wait[e_dqopc*N + j] = 1'b0;
        s_wait[j*N + e_dqopc] = 1'b0;
      end
    end
    if (s_pv) begin
      if (s_rand_wait) begin
        for (int j = 0; j < N; j++) begin
          if (j != s_popc && s_busy[j]) s_wait[s_popc*N + j] = 1'($urandom_range(0, 1));
        end
      end
      s_busy[s_popc] = 1'b1;
    end
    s_pv   = e_fire_a;
    s_popc = e_aopc;
  endtask

  task automatic cycle();
    eval();
    adv();
  endtask

  task automatic clr_sched();
    s_busy = '0; s_ready = '0; s_wait = '0; s_pv = 0; s_popc = 0;
    s_auto_clear = 1; s_rand_wait = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.alloc_valid    = 1'b0;
    bus.dispatch_ready = 1'b0;
    cycle();
    reset = 1'b0;
    clr_sched();
  endtask

  initial begin
    reset = 1'b1;
    bus.alloc_valid    = 1'b0;
    bus.dispatch_ready = 1'b1;
    clr_sched();
    bus.opc_busy = '0; bus.opc_ready = '0; bus.opc_wait_mask = '0;
    m_dv = 0; m_dop = 0; m_rr = 0; m_hv = 0; m_hold = 0; m_stalls = '0;
    @(posedge clk);
    #1;
    chk("rst_dispatch_valid", 32'(bus.dispatch_valid), 32'd0);
    chk("rst_dispatch_opc", 32'(bus.dispatch_opc), 32'd0);
    chk("rst_perf_stalls", bus.perf_stalls, 32'd0);
    chk("rst_dequeue", 32'(bus.dequeue), 32'd0);
    reset = 1'b0;
    bus.dispatch_ready = 1'b0;

    // Back-to-back allocation while busy lags the grant.
    bus.alloc_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      eval();
      chk("alloc_seq", 32'(bus.alloc_opc), 32'(k));
      adv();
    end
    eval();
    chk("alloc_full", 32'(bus.alloc_ready), 32'd0);
    adv();
    bus.alloc_valid = 1'b0;
    cycle();

    // All OPCs busy and ready: round-robin one per cycle with wrap.
    s_ready = 4'b1111;
    s_auto_clear = 0;
    bus.dispatch_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("rr_order", 32'(bus.dispatch_opc), 32'(k % N));
    end
    s_ready = '0;
    cycle();

    // Wait mask: OPC2 waits on OPC1.
    do_reset();
    s_busy = 4'b0110; s_ready = 4'b0110; s_wait[2*N + 1] = 1'b1;
    bus.dispatch_ready = 1'b1;
    cycle();
    chk("wait_first", 32'(bus.dispatch_opc), 32'd1);
    cycle();
    chk("wait_gap", 32'(bus.dispatch_valid), 32'd0);
    cycle();
    chk("wait_second_v", 32'(bus.dispatch_valid), 32'd1);
    chk("wait_second", 32'(bus.dispatch_opc), 32'd2);
    cycle();

    // Stall with OPC3 held for 5 cycles.
    do_reset();
    s_busy = 4'b1000; s_ready = 4'b1000;
    bus.dispatch_ready = 1'b0;
    cycle();
    for (int k = 0; k < 5; k++) begin
      eval();
      chk("stall_deq", 32'(bus.dequeue), 32'd0);
      adv();
      chk("stall_opc", 32'(bus.dispatch_opc), 32'd3);
    end
    chk("stall_count", bus.perf_stalls, 32'd5);
    bus.dispatch_ready = 1'b1;
    cycle();

    // Reset while a dispatch is held.
    do_reset();
    s_busy = 4'b1100; s_ready = 4'b1100;
    bus.dispatch_ready = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
    eval();
    chk("rst_held_deq", 32'(bus.dequeue), 32'd0);
    adv();
    reset = 1'b0;
    chk("rst_held_valid", 32'(bus.dispatch_valid), 32'd0);
    chk("rst_held_opc", 32'(bus.dispatch_opc), 32'd0);
    s_busy = 4'b1111; s_ready = 4'b1111;
    bus.dispatch_ready = 1'b1;
    cycle();
    chk("rst_rr_ptr", 32'(bus.dispatch_opc), 32'd0);

    // OPC0 dequeued at t, reallocated at t+1.
    do_reset();
    s_busy = 4'b1111; s_ready = 4'b0001;
    bus.dispatch_ready = 1'b1;
    cycle();
    cycle();
    bus.alloc_valid = 1'b1;
    eval();
    chk("realloc_ready", 32'(bus.alloc_ready), 32'd1);
    chk("realloc_opc", 32'(bus.alloc_opc), 32'd0);
    adv();
    bus.alloc_valid = 1'b0;

    // Randomized traffic with acyclic wait masks.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) do_reset();
      s_rand_wait = 1;
      bus.alloc_valid    = 1'($urandom_range(0, 1));
      bus.dispatch_ready = ($urandom_range(0, 3) != 0);
      s_ready = s_ready | (N'($urandom) & s_busy);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
